// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StCheck,
    StDone,
    StError
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CKSUM_W        = 8;

  function automatic int unsigned imem_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; word_o already includes
// a byte accepted this cycle so the caller can capture a full word on word_full_o.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);

  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     word_q, word_d;

  always_comb begin
    word_d      = {word_q[23:0], byte_i};
    idx_d       = idx_q + 1'b1;
    word_full_o = accept_i && (idx_q == IdxW'(BYTES_PER_WORD - 1));
    word_o      = accept_i ? word_d : word_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (accept_i) begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory and releases the CPU once the image is complete.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wd,
  output logic              busy,
  output logic              cpu_run,
  output logic              err
);

  localparam int unsigned Depth = imem_depth(ADDR_W);

  state_e          state_q;
  logic [ADDR_W:0] count_q;
  // One bit wider than the address so a full-depth load compares before wrapping.
  logic [ADDR_W:0] widx_q;
  logic [ADDR_W:0] widx_inc;
  logic            imem_we_q, cpu_run_q, err_q;
  logic [31:0]     imem_addr_q, imem_wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CKSUM_W-1:0] sum_q;
`endif

  logic        accept, start_ok, pk_full;
  logic [31:0] pk_word;

  always_comb begin
    in_ready = (state_q == StLoad) || (state_q == StCheck);
    busy     = (state_q == StLoad) || (state_q == StWrite) || (state_q == StCheck);
    accept   = in_valid && in_ready;
    start_ok = start && ((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
    widx_inc = widx_q + 1'b1;
  end

  assign imem_we   = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_wd   = imem_wd_q;
  assign cpu_run   = cpu_run_q;
  assign err       = err_q;

  byte_packer u_packer (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .clear_i     (start_ok),
    .accept_i    (accept && (state_q == StLoad)),
    .byte_i      (in_data),
    .word_o      (pk_word),
    .word_full_o (pk_full)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      count_q     <= '0;
      widx_q      <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_wd_q   <= '0;
      cpu_run_q   <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            count_q   <= word_count;
            widx_q    <= '0;
            cpu_run_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
            if (word_count == '0 || 32'(word_count) > Depth) begin
              state_q <= StError;
              err_q   <= 1'b1;
            end else begin
              state_q <= StLoad;
              err_q   <= 1'b0;
            end
          end
        end
        StLoad: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) sum_q <= sum_q + in_data;
`endif
          if (pk_full) begin
            imem_we_q   <= 1'b1;
            imem_addr_q <= 32'(widx_q[ADDR_W-1:0]);
            imem_wd_q   <= pk_word;
            state_q     <= StWrite;
          end
        end
        StWrite: begin
          widx_q <= widx_inc;
          if (widx_inc == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q <= StCheck;
`else
            state_q   <= StDone;
            cpu_run_q <= 1'b1;
`endif
          end else begin
            state_q <= StLoad;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StCheck: begin
          if (in_valid) begin
            if (in_data == sum_q) begin
              state_q   <= StDone;
              cpu_run_q <= 1'b1;
            end else begin
              state_q <= StError;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
